// File: rtl/cam_capture_pkg.sv
// ============================================================================
// Module  : cam_capture_pkg
// Brief   : Shared FSM state type, RGB332 packing helper and default frame size
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cam_capture_pkg;

    localparam int H_PIX_DEFAULT   = 160;
    localparam int V_LINES_DEFAULT = 120;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VS = 2'd1,
        ST_CAPTURE = 2'd2
    } cap_state_t;

    // Operands are the bits that survive the 565 -> 332 reduction only.
    function automatic logic [7:0] rgb332(input logic [2:0] red,
                                          input logic [2:0] green,
                                          input logic [1:0] blue);
        return {red, green, blue};
    endfunction

endpackage

`default_nettype wire

// File: rtl/cam_sync_reg.sv
// ============================================================================
// Module  : cam_sync_reg
// Brief   : Parametrised-width register on a selectable pclk edge, async reset
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_sync_reg #(
    parameter int WIDTH    = 1,
    parameter bit NEG_EDGE = 1'b1
) (
    input  logic             clk,
    input  logic             async_reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (NEG_EDGE) begin : g_neg_edge
            always_ff @(negedge clk or posedge async_reset) begin
                if (async_reset) begin
                    dout <= '0;
                end else begin
                    dout <= din;
                end
            end
        end else begin : g_pos_edge
            always_ff @(posedge clk or posedge async_reset) begin
                if (async_reset) begin
                    dout <= '0;
                end else begin
                    dout <= din;
                end
            end
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/cam_pixel_capture.sv
// ============================================================================
// Module  : cam_pixel_capture
// Brief   : OV7670 RGB565 byte-pair capture into RGB332 frame buffer writes.
//           Optional framing-error flag enabled by macro CAM_CAPTURE_ERR_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_pixel_capture
    import cam_capture_pkg::*;
#(
    parameter bit NEG_EDGE = 1'b1,
    parameter int H_PIX    = H_PIX_DEFAULT,
    parameter int V_LINES  = V_LINES_DEFAULT,
    parameter int AW       = 15
) (
    input  logic          pclk,
    input  logic          async_reset,
    input  logic          en,
    input  logic          vsync,
    input  logic          href,
    input  logic [7:0]    d,
    output logic [7:0]    px_data,
    output logic [AW-1:0] px_addr,
    output logic          px_we,
    output logic          busy,
    output logic          frame_done,
    output logic          err
);

    // Column saturates one past H_PIX so over-long lines stay distinguishable.
    localparam int CW = $clog2(H_PIX + 2);
    localparam int LW = $clog2(V_LINES + 1);
    localparam logic [CW-1:0] c_H_PIX   = CW'(H_PIX);
    localparam logic [CW-1:0] c_COL_MAX = CW'(H_PIX + 1);
    localparam logic [LW-1:0] c_V_LINES = LW'(V_LINES);

    typedef struct packed {
        logic          vs_d;
        logic          href_d;
        logic          phase;
        logic [5:0]    hi6;
        logic [CW-1:0] col;
        logic [LW-1:0] line;
        logic [AW-1:0] next_addr;
        logic [7:0]    px_data;
        logic [AW-1:0] px_addr;
        logic          px_we;
        logic          frame_done;
`ifdef CAM_CAPTURE_ERR_EN
        logic          err;
`endif
    } dp_t;

    logic       r_vs;
    logic       r_href;
    logic [7:0] r_d;
    logic [1:0] r_state_bits;
    cap_state_t r_state;
    cap_state_t w_state_nxt;
    dp_t        r_dp;
    dp_t        w_dp_nxt;
    logic       w_vs_fall;
    logic       w_vs_rise;
    logic       w_href_fall;
    logic       w_start;
    logic       w_in_window;

    cam_sync_reg #(.WIDTH(10), .NEG_EDGE(NEG_EDGE)) u_in_reg (
        .clk         (pclk),
        .async_reset (async_reset),
        .din         ({vsync, href, d}),
        .dout        ({r_vs, r_href, r_d})
    );

    // State register
    cam_sync_reg #(.WIDTH(2), .NEG_EDGE(NEG_EDGE)) u_state_reg (
        .clk         (pclk),
        .async_reset (async_reset),
        .din         (w_state_nxt),
        .dout        (r_state_bits)
    );
    assign r_state = cap_state_t'(r_state_bits);

    cam_sync_reg #(.WIDTH($bits(dp_t)), .NEG_EDGE(NEG_EDGE)) u_dp_reg (
        .clk         (pclk),
        .async_reset (async_reset),
        .din         (w_dp_nxt),
        .dout        (r_dp)
    );

    assign w_vs_fall   = r_dp.vs_d & ~r_vs;
    assign w_vs_rise   = ~r_dp.vs_d & r_vs;
    assign w_href_fall = r_dp.href_d & ~r_href;
    assign w_in_window = (r_dp.col < c_H_PIX) && (r_dp.line < c_V_LINES);

    // Next-state logic; a disarm during capture waits for the frame end.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (en) w_state_nxt = ST_WAIT_VS;
            ST_WAIT_VS: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_vs_fall) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: if (w_vs_rise) w_state_nxt = en ? ST_WAIT_VS : ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy    = (r_state != ST_IDLE);
        w_start = (r_state == ST_WAIT_VS) && (w_state_nxt == ST_CAPTURE);
    end

    always_comb begin
        w_dp_nxt            = r_dp;
        w_dp_nxt.vs_d       = r_vs;
        w_dp_nxt.href_d     = r_href;
        w_dp_nxt.px_we      = 1'b0;
        w_dp_nxt.frame_done = 1'b0;
        if (w_start) begin
            w_dp_nxt.phase     = 1'b0;
            w_dp_nxt.col       = '0;
            w_dp_nxt.line      = '0;
            w_dp_nxt.next_addr = '0;
            w_dp_nxt.px_addr   = '0;
`ifdef CAM_CAPTURE_ERR_EN
            w_dp_nxt.err       = 1'b0;
`endif
        end else if (r_state == ST_CAPTURE) begin
            if (w_vs_rise) begin
                w_dp_nxt.frame_done = 1'b1;
            end
            // Bytes seen during vertical blanking are discarded.
            if (r_href && !r_vs) begin
                if (!r_dp.phase) begin
                    w_dp_nxt.hi6   = {r_d[7:5], r_d[2:0]};
                    w_dp_nxt.phase = 1'b1;
                end else begin
                    w_dp_nxt.phase = 1'b0;
                    if (r_dp.col != c_COL_MAX) begin
                        w_dp_nxt.col = r_dp.col + CW'(1);
                    end
                    if (w_in_window) begin
                        w_dp_nxt.px_we     = 1'b1;
                        w_dp_nxt.px_data   = rgb332(r_dp.hi6[5:3], r_dp.hi6[2:0], r_d[4:3]);
                        w_dp_nxt.px_addr   = r_dp.next_addr;
                        w_dp_nxt.next_addr = r_dp.next_addr + AW'(1);
                    end
                end
            end else if (w_href_fall) begin
`ifdef CAM_CAPTURE_ERR_EN
                if (r_dp.phase || ((r_dp.col != c_H_PIX) && (r_dp.line < c_V_LINES))) begin
                    w_dp_nxt.err = 1'b1;
                end
`endif
                w_dp_nxt.phase = 1'b0;
                if (r_dp.col != '0) begin
                    w_dp_nxt.col = '0;
                    if (r_dp.line != c_V_LINES) begin
                        w_dp_nxt.line = r_dp.line + LW'(1);
                    end
                end
            end
        end
    end

    assign px_data    = r_dp.px_data;
    assign px_addr    = r_dp.px_addr;
    assign px_we      = r_dp.px_we;
    assign frame_done = r_dp.frame_done;
`ifdef CAM_CAPTURE_ERR_EN
    assign err        = r_dp.err;
`else
    assign err        = 1'b0;
`endif

endmodule

`default_nettype wire
